// File: rtl/tx_control_pkg.sv
// tx_pkg: shared record geometry, terminator byte and FSM state encoding for the host-link control units
package tx_pkg;
  localparam int BYTES_PER_RECORD = 16;
  localparam logic [7:0] TERMINATOR_BYTE = 8'h00;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, SETTLE, DRAIN, TERM, DONE} tx_state_t;
endpackage

// File: rtl/tx_control_if.sv
// tx_control_if: result-memory read port plus UART TX load/busy handshake
interface tx_control_if #(parameter int ADDR_W = 16);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  modport master (output rd_en, rd_addr, tx_start, tx_byte, input rd_data, tx_busy);
  modport slave (input rd_en, rd_addr, tx_start, tx_byte, output rd_data, tx_busy);
endinterface

// File: rtl/tx_control.sv
// tx_control: streams record_count records from result memory to the UART TX, byte by byte.
// Define TX_TERMINATOR_EN to close every stream with a single terminator byte.
module tx_control import tx_pkg::*; #(
  parameter int BYTES_PER_RECORD = tx_pkg::BYTES_PER_RECORD,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] record_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] records_sent,
  tx_control_if.master      bus
);
  localparam int CW = $clog2(BYTES_PER_RECORD);
`ifdef TX_TERMINATOR_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif
  tx_state_t         state;
  logic [ADDR_W-1:0] count;
  logic [CW-1:0]     byte_cnt;
  logic              term_sent;
  logic              last_byte;
  assign last_byte = (&byte_cnt) && (records_sent + 1'b1 == count);
  // Outputs are registered one state ahead, so each assignment here describes the next cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_byte  <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      records_sent <= '0;
      count        <= '0;
      byte_cnt     <= '0;
      term_sent    <= 1'b0;
    end else begin
      bus.rd_en    <= 1'b0;
      bus.tx_start <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count        <= record_count;
          bus.rd_addr  <= '0;
          byte_cnt     <= '0;
          records_sent <= '0;
          term_sent    <= 1'b0;
          busy         <= 1'b1;
          bus.rd_en    <= record_count != '0;
          state        <= record_count != '0 ? FETCH : TERM_EN ? TERM : DONE;
        end
        FETCH: state <= WAIT;
        WAIT: begin
          bus.tx_byte  <= bus.rd_data;
          bus.tx_start <= !bus.tx_busy;
          state        <= SEND;
        end
        TERM: begin
          bus.tx_byte  <= TERMINATOR_BYTE;
          bus.tx_start <= !bus.tx_busy;
          term_sent    <= 1'b1;
          state        <= SEND;
        end
        // A pulse already issued moves on; otherwise keep retrying until the UART is free
        SEND: begin
          bus.tx_start <= !bus.tx_start && !bus.tx_busy;
          state        <= bus.tx_start ? SETTLE : SEND;
        end
        SETTLE: state <= DRAIN;
        DRAIN: if (!bus.tx_busy) begin
          if (term_sent) state <= DONE;
          else begin
            bus.rd_addr  <= bus.rd_addr + 1'b1;
            byte_cnt     <= byte_cnt + 1'b1;
            records_sent <= (&byte_cnt) ? records_sent + 1'b1 : records_sent;
            bus.rd_en    <= !last_byte;
            state        <= !last_byte ? FETCH : TERM_EN ? TERM : DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: directed vectors plus multi-cycle corner sequences for tx_control with memory and UART models
module tb_tx_control;
  import tx_pkg::*;
`ifdef TX_TERMINATOR_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [15:0] record_count = '0;
  logic        busy, done;
  logic [15:0] records_sent;
  logic        ext_busy = 0;
  int          ucnt = 0;
  int          done_cnt = 0;
  int          d_before = 0;
  int          total = 0;
  int          passed = 0;
  logic [7:0]  mem [0:255];
  logic [7:0]  tx_log [$];
  tx_control_if #(.ADDR_W(16)) bus();
  tx_control dut (
    .clk(clk), .reset(reset), .start(start), .record_count(record_count),
    .busy(busy), .done(done), .records_sent(records_sent), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.tx_busy = (ucnt != 0) || ext_busy;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[7:0]];
  always @(posedge clk) begin
    if (bus.tx_start) begin
      tx_log.push_back(bus.tx_byte);
      ucnt <= 10;
    end else if (ucnt > 0) ucnt <= ucnt - 1;
    if (done) done_cnt <= done_cnt + 1;
  end
  typedef struct {
    logic [15:0] cnt;
    int          pat;
    int          nbytes;
    logic [15:0] recs;
  } vec_t;
  vec_t vecs [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic set_mem(input int pat);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    if (pat == 1) begin
      mem[3] = 8'h00;
      mem[20] = 8'h00;
    end
  endtask
  task automatic start_xfer(input logic [15:0] c);
    @(negedge clk);
    d_before = done_cnt;
    record_count = c;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && done_cnt == d_before; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({name, " done pulses"}, done_cnt - d_before, 1);
  endtask
  task automatic wait_bytes(input int n);
    for (int i = 0; i < 3000 && tx_log.size() < n; i++) @(negedge clk);
    chk("bytes reached", tx_log.size() >= n, 1);
  endtask
  task automatic chk_bytes(input string name, input logic [15:0] c);
    int bad = 0;
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] !== (i < c * 16 ? mem[i] : 8'h00)) bad++;
    chk({name, " byte errors"}, bad, 0);
  endtask
  initial begin
    vecs[0] = '{cnt: 16'd2, pat: 0, nbytes: 32 + TERM, recs: 16'd2};
    vecs[1] = '{cnt: 16'd1, pat: 1, nbytes: 16 + TERM, recs: 16'd1};
    vecs[2] = '{cnt: 16'd0, pat: 0, nbytes: TERM, recs: 16'd0};
    vecs[3] = '{cnt: 16'd3, pat: 1, nbytes: 48 + TERM, recs: 16'd3};
    set_mem(0);
    repeat (3) @(negedge clk);
    chk("rst rd_en", bus.rd_en, 0);
    chk("rst rd_addr", bus.rd_addr, 0);
    chk("rst tx_start", bus.tx_start, 0);
    chk("rst tx_byte", bus.tx_byte, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst records_sent", records_sent, 0);
    @(negedge clk);
    reset = 0;
    for (int v = 0; v < 4; v++) begin
      set_mem(vecs[v].pat);
      tx_log.delete();
      start_xfer(vecs[v].cnt);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d nbytes", v), tx_log.size(), vecs[v].nbytes);
      chk($sformatf("vec%0d records_sent", v), records_sent, vecs[v].recs);
      chk($sformatf("vec%0d busy", v), busy, 0);
      chk_bytes($sformatf("vec%0d", v), vecs[v].cnt);
    end
    set_mem(0);
    tx_log.delete();
    @(negedge clk);
    d_before = done_cnt;
    record_count = 16'd1;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("lat rd_en E0", bus.rd_en, 1);
    chk("lat rd_addr E0", bus.rd_addr, 0);
    chk("lat busy E0", busy, 1);
    @(negedge clk);
    chk("lat rd_en E1", bus.rd_en, 0);
    @(negedge clk);
    chk("lat tx_start E2", bus.tx_start, 1);
    chk("lat tx_byte E2", bus.tx_byte, 8'h01);
    @(negedge clk);
    chk("lat tx_start E3", bus.tx_start, 0);
    wait_done("lat");
`ifndef TX_TERMINATOR_EN
    tx_log.delete();
    @(negedge clk);
    d_before = done_cnt;
    record_count = 16'd0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("zero done E0", done, 0);
    chk("zero busy E0", busy, 1);
    @(negedge clk);
    chk("zero done E1", done, 1);
    chk("zero busy E1", busy, 0);
    repeat (3) @(negedge clk);
    chk("zero tx_start count", tx_log.size(), 0);
    chk("zero done pulses", done_cnt - d_before, 1);
`endif
    tx_log.delete();
    ext_busy = 1;
    start_xfer(16'd1);
    repeat (20) @(negedge clk);
    chk("stall no tx_start", tx_log.size(), 0);
    chk("stall busy", busy, 1);
    ext_busy = 0;
    wait_done("stall");
    chk("stall nbytes", tx_log.size(), 16 + TERM);
    chk("stall first byte", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h01);
    tx_log.delete();
    start_xfer(16'd2);
    wait_bytes(5);
    @(negedge clk);
    record_count = 16'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("restart");
    chk("restart nbytes", tx_log.size(), 32 + TERM);
    chk("restart records_sent", records_sent, 2);
    chk_bytes("restart", 16'd2);
    tx_log.delete();
    start_xfer(16'd2);
    wait_bytes(7);
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("mid rst rd_en", bus.rd_en, 0);
    chk("mid rst rd_addr", bus.rd_addr, 0);
    chk("mid rst tx_start", bus.tx_start, 0);
    chk("mid rst tx_byte", bus.tx_byte, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst records_sent", records_sent, 0);
    @(negedge clk);
    reset = 0;
    repeat (15) @(negedge clk);
    chk("mid rst no done", done_cnt - d_before, 0);
    tx_log.delete();
    start_xfer(16'd1);
    wait_done("resend");
    chk("resend nbytes", tx_log.size(), 16 + TERM);
    chk("resend first byte", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h01);
    chk_bytes("resend", 16'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
